// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: word width, the four control symbols and the
// three-lane symbol group layout used by the serializer.
package tmds_pkg;

    localparam int TMDS_WORD_W = 10;

    localparam logic [TMDS_WORD_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_WORD_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_WORD_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_WORD_W-1:0] CTRL_11 = 10'b1010101011;

    // lane2 (red) occupies [29:20], lane1 (green) [19:10], lane0 (blue) [9:0]
    typedef struct packed {
        logic [TMDS_WORD_W-1:0] lane2;
        logic [TMDS_WORD_W-1:0] lane1;
        logic [TMDS_WORD_W-1:0] lane0;
    } tmds_group_t;

endpackage

// File: rtl/tmds_lane_shifter.sv
// One TMDS lane: parallel-load 10-bit shifter whose end flop drives the
// serial output directly, transmitting LSB or MSB first.
module tmds_lane_shifter
    import tmds_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [TMDS_WORD_W-1:0] word,
    output logic                   serial
);

    logic [TMDS_WORD_W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= word;
        end else if (LSB_FIRST) begin
            shreg <= {1'b0, shreg[TMDS_WORD_W-1:1]};
        end else begin
            shreg <= {shreg[TMDS_WORD_W-2:0], 1'b0};
        end
    end

    assign serial = LSB_FIRST ? shreg[0] : shreg[TMDS_WORD_W-1];

endmodule

// File: rtl/tmds_serializer.sv
// Fabric 10:1 TMDS serializer: one-deep symbol hold register, bit counter,
// three lane shifters and the 5-high/5-low TMDS clock pattern.
module tmds_serializer
    import tmds_pkg::*;
#(
    parameter logic [TMDS_WORD_W-1:0] IDLE_SYMBOL = CTRL_00,
    parameter bit                     LSB_FIRST   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] sym_data,
    input  logic        sym_valid,
    output logic        sym_ready,
    output logic [2:0]  tmds,
    output logic        tmds_clock,
    output logic        underrun
);

    logic [3:0]  bit_cnt;
    tmds_group_t hold;
    logic        hold_full;
    logic        started;
    logic        load_point;
    logic        xfer;
    logic [TMDS_WORD_W-1:0] lane_word [3];

    // Counter values above 9 cannot occur but are treated as a load point
    assign load_point = (bit_cnt >= 4'd9);
    assign sym_ready  = !reset && (!hold_full || load_point);
    assign xfer       = sym_valid && sym_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= 4'd9;
            hold       <= '0;
            hold_full  <= 1'b0;
            started    <= 1'b0;
            tmds_clock <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (load_point) begin
                bit_cnt    <= 4'd0;
                tmds_clock <= 1'b1;
                underrun   <= started && !hold_full;
            end else begin
                bit_cnt    <= bit_cnt + 4'd1;
                tmds_clock <= (bit_cnt < 4'd4);
                underrun   <= 1'b0;
            end
            // A transfer on a load cycle refills the hold after its old contents go to the shifters
            if (xfer) begin
                hold      <= tmds_group_t'(sym_data);
                hold_full <= 1'b1;
                started   <= 1'b1;
            end else if (load_point) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign lane_word[0] = hold_full ? hold.lane0 : IDLE_SYMBOL;
    assign lane_word[1] = hold_full ? hold.lane1 : IDLE_SYMBOL;
    assign lane_word[2] = hold_full ? hold.lane2 : IDLE_SYMBOL;

    for (genvar i = 0; i < 3; i++) begin : g_lane
        tmds_lane_shifter #(
            .LSB_FIRST (LSB_FIRST)
        ) u_shifter (
            .clk    (clk),
            .reset  (reset),
            .load   (load_point),
            .word   (lane_word[i]),
            .serial (tmds[i])
        );
    end

endmodule

// File: tb/tb_tmds_serializer.sv
// Directed bench for tmds_serializer: an LSB-first instance driven through
// idle, streaming, starvation and mid-word reset, plus an MSB-first instance.
module tb_tmds_serializer;

    localparam logic [9:0]  IDLE_W = 10'b1101010100;
    localparam logic [29:0] IDLE_G = {IDLE_W, IDLE_W, IDLE_W};
    localparam logic [29:0] SYM_A  = {10'h3FF, 10'h000, 10'h2AA};
    localparam logic [29:0] SYM_B  = {10'h155, 10'h3FF, 10'h0F0};
    localparam logic [29:0] SYM_E  = {10'h0AB, 10'h1CD, 10'h3EF};
    localparam logic [9:0]  MSB_W  = 10'b1000000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] sym_data;
    logic        sym_valid;
    logic        sym_ready;
    logic [2:0]  tmds;
    logic        tmds_clock;
    logic        underrun;

    logic [29:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  m_tmds;
    logic        m_clock;
    logic        m_underrun;

    int          n_checks = 0;
    int          n_errors = 0;
    int          xfer_count = 0;
    logic [29:0] pending [$];

    always #5 clk = ~clk;

    tmds_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .sym_data   (sym_data),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .tmds       (tmds),
        .tmds_clock (tmds_clock),
        .underrun   (underrun)
    );

    tmds_serializer #(
        .LSB_FIRST (1'b0)
    ) dut_msb (
        .clk        (clk),
        .reset      (reset),
        .sym_data   (m_data),
        .sym_valid  (m_valid),
        .sym_ready  (m_ready),
        .tmds       (m_tmds),
        .tmds_clock (m_clock),
        .underrun   (m_underrun)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one bit period; the upstream model retires a symbol on each handshake
    task automatic step();
        logic fire;
        fire = sym_valid && sym_ready;
        @(posedge clk);
        @(negedge clk);
        if (fire) begin
            xfer_count++;
            if (pending.size() > 0) sym_data = pending.pop_front();
            else sym_valid = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic [29:0] grp);
        pending.push_back(grp);
        if (!sym_valid) begin
            sym_data  = pending.pop_front();
            sym_valid = 1'b1;
        end
    endtask

    task automatic check_word(input string tag, input logic [29:0] grp, input logic [9:0] rdy_mask,
                              input logic und_first, input int n, input bit chk_msb,
                              input logic [9:0] msb_word);
        logic [2:0] exp_tmds;
        for (int k = 0; k < n; k++) begin
            exp_tmds = {grp[20+k], grp[10+k], grp[k]};
            check_output({tag, " tmds"}, 32'(tmds), 32'(exp_tmds));
            check_output({tag, " tmds_clock"}, 32'(tmds_clock), 32'(k < 5));
            check_output({tag, " sym_ready"}, 32'(sym_ready), 32'(rdy_mask[k]));
            check_output({tag, " underrun"}, 32'(underrun), 32'((k == 0) ? und_first : 1'b0));
            if (chk_msb) check_output({tag, " msb tmds"}, 32'(m_tmds), 32'({3{msb_word[9-k]}}));
            step();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " tmds"}, 32'(tmds), 32'd0);
        check_output({tag, " tmds_clock"}, 32'(tmds_clock), 32'd0);
        check_output({tag, " sym_ready"}, 32'(sym_ready), 32'd0);
        check_output({tag, " underrun"}, 32'(underrun), 32'd0);
        check_output({tag, " msb tmds"}, 32'(m_tmds), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        sym_valid = 1'b0;
        sym_data  = '0;
        m_valid   = 1'b1;
        m_data    = {MSB_W, MSB_W, MSB_W};
        step();
        step();
        check_reset_state("reset");
        reset = 1'b0;
        step();

        // Idle link: control symbol on every lane, no underrun before streaming
        check_word("idle1", IDLE_G, 10'h3FF, 1'b0, 10, 1'b1, IDLE_W);
        check_word("idle2", IDLE_G, 10'h3FF, 1'b0, 10, 1'b1, MSB_W);

        // Back-to-back A then B; B is taken on the load cycle while A is held
        apply_stimulus(SYM_A);
        apply_stimulus(SYM_B);
        check_word("stream_w0", IDLE_G, 10'b1000000001, 1'b0, 10, 1'b0, MSB_W);
        check_word("stream_a", SYM_A, 10'b1000000000, 1'b0, 10, 1'b0, MSB_W);
        check_word("stream_b", SYM_B, 10'h3FF, 1'b0, 10, 1'b0, MSB_W);
        check_word("starve1", IDLE_G, 10'h3FF, 1'b1, 10, 1'b0, MSB_W);

        // Single A then upstream stops
        apply_stimulus(SYM_A);
        check_word("single_w0", IDLE_G, 10'b1000000001, 1'b1, 10, 1'b0, MSB_W);
        check_word("single_a", SYM_A, 10'h3FF, 1'b0, 10, 1'b0, MSB_W);

        // Hold E, then reset at bit_cnt 4 discards it
        apply_stimulus(SYM_E);
        check_word("pre_reset", IDLE_G, 10'b1000000001, 1'b1, 4, 1'b0, MSB_W);
        reset = 1'b1;
        step();
        check_reset_state("midword_reset");
        reset = 1'b0;
        step();
        check_word("post_reset1", IDLE_G, 10'h3FF, 1'b0, 10, 1'b1, IDLE_W);
        check_word("post_reset2", IDLE_G, 10'h3FF, 1'b0, 10, 1'b1, MSB_W);

        check_output("transfer count", 32'(xfer_count), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
